// File: rtl/regfile_pkg.sv
// Shared constants and the address-width helper for the register file scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned NRP_DEF  = 2;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_busy_tracker.sv
// Pending-write bit per register, issue/write/flush arbitration and the pending count.
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter int unsigned NREG     = NREG_DEF,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned AW       = clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic            iss_en_i,
  input  logic [AW-1:0]   iss_rd_i,
  input  logic            flush_i,
  output logic [NREG-1:0] busy_o,
  output logic            iss_ready_c_o,
  output logic [AW:0]     busy_cnt_o
);

  localparam int unsigned CW = AW + 1;

  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_eff, iss_acc, cnt_inc, cnt_dec;

  always_comb begin
    busy_d        = busy_q;
    cnt_d         = cnt_q;
    iss_ready_c_o = !busy_q[iss_rd_i] || (wr_en_i && (wr_addr_i == iss_rd_i));
    wr_eff        = wr_en_i && !((ZERO_REG != 0) && (wr_addr_i == '0));
    iss_acc       = iss_en_i && iss_ready_c_o && !flush_i &&
                    !((ZERO_REG != 0) && (iss_rd_i == '0));
    // Issue wins over a same-register write: the bit stays set, count is unchanged.
    cnt_inc       = iss_acc && !busy_q[iss_rd_i];
    cnt_dec       = wr_eff && busy_q[wr_addr_i] && !(iss_acc && (iss_rd_i == wr_addr_i));

    if (wr_eff)  busy_d[wr_addr_i] = 1'b0;
    if (iss_acc) busy_d[iss_rd_i]  = 1'b1;
    cnt_d = cnt_q + CW'(cnt_inc) - CW'(cnt_dec);

    if (flush_i) begin
      busy_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write bypass and a per-register pending-write scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN     = XLEN_DEF,
  parameter  int unsigned NREG     = NREG_DEF,
  parameter  int unsigned NRP      = NRP_DEF,
  parameter  int unsigned ZERO_REG = 1,
  parameter  int unsigned BYPASS   = 1,
  localparam int unsigned AW       = clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  input  logic                flush,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy;
  logic            iss_ready_c;
  logic            wr_we;

  regfile_busy_tracker #(
    .NREG     (NREG),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_busy (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .iss_en_i      (iss_en),
    .iss_rd_i      (iss_rd),
    .flush_i       (flush),
    .busy_o        (busy),
    .iss_ready_c_o (iss_ready_c),
    .busy_cnt_o    (busy_cnt)
  );

  assign wr_we     = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
  assign iss_ready = iss_ready_c || !reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else if (wr_we) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Read ports; outputs are forced quiet while reset is asserted.
  for (genvar p = 0; p < int'(NRP); p++) begin : g_rd
    logic [AW-1:0] addr;
    logic          zero_hit;
    logic          fwd;

    assign addr     = rd_addr[p*AW +: AW];
    assign zero_hit = (ZERO_REG != 0) && (addr == '0);
    assign fwd      = (BYPASS != 0) && wr_en && (addr == wr_addr) && !zero_hit;

    assign rd_data[p*XLEN +: XLEN] = (!reset_n || zero_hit) ? '0 :
                                     fwd                    ? wr_data :
                                                              regs_q[addr];
    assign rd_busy[p] = reset_n && !fwd && busy[addr];
  end

endmodule
